// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, with optional half-up rounding.
// Latency WIDTH+1 cycles from start acceptance to the done pulse; start is ignored while busy.
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int ROUND = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ROUND} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_done;
  logic [WIDTH-1:0] r_quot_out;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_dz;
  logic             w_round_up;

  // The stored partial remainder is always below the divisor, so only the
  // working value after the shift needs the extra sign bit.
  assign w_shift    = {r_prem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_dz       = (r_dvs == '0);
  assign w_round_up = (ROUND != 0) && ({r_prem, 1'b0} >= {1'b0, r_dvs}) && (r_quo != '1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_next = S_ROUND;
      end
      S_ROUND: begin
        o_busy = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_prem     <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_done     <= 1'b0;
      r_quot_out <= '0;
      r_rem_out  <= '0;
      r_dz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_quo  <= i_dividend;
            r_dvs  <= i_divisor;
            r_prem <= '0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (!w_diff[WIDTH]) begin
            r_prem <= w_diff[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_prem <= w_shift[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        S_ROUND: begin
          r_done    <= 1'b1;
          r_dz      <= w_dz;
          r_rem_out <= r_prem;
          if (w_dz)            r_quot_out <= '1;
          else if (w_round_up) r_quot_out <= r_quo + WIDTH'(1);
          else                 r_quot_out <= r_quo;
        end
        default: ;
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quot_out;
  assign o_remainder = r_rem_out;
  assign o_div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, monitors pop on done.
module tb_seq_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start0;
  logic [15:0] dividend, divisor;
  logic        busy, done, dz;
  logic [15:0] quo, rem;
  logic        busy0, done0, dz0;
  logic [15:0] quo0, rem0;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t sb0[$];

  seq_divider #(.WIDTH(16), .ROUND(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy), .o_done(done), .o_quotient(quo),
    .o_remainder(rem), .o_div_zero(dz)
  );

  seq_divider #(.WIDTH(16), .ROUND(0)) dut_trunc (
    .i_clk(clk), .i_reset(reset), .i_start(start0),
    .i_dividend(dividend), .i_divisor(divisor),
    .o_busy(busy0), .o_done(done0), .o_quotient(quo0),
    .o_remainder(rem0), .o_div_zero(dz0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(quo), 32'(e.q));
        chk("remainder", 32'(rem), 32'(e.r));
        chk("div_zero", 32'(dz), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done0) begin
      if (sb0.size() == 0) begin
        chk("trunc_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb0.pop_front();
        chk("trunc_quotient", 32'(quo0), 32'(e.q));
        chk("trunc_remainder", 32'(rem0), 32'(e.r));
        chk("trunc_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Done is seen at the negedge of the cycle 18 edges after start is driven.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic z);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back('{q: q, r: r, dz: z, cyc: cyc + 18});
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (sb.size() != 0 || sb0.size() != 0); i++) tick(1);
    if (sb.size() != 0 || sb0.size() != 0) begin
      chk("done_timeout", 32'(sb.size() + sb0.size()), 32'd0);
      sb.delete();
      sb0.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset    = 1'b1;
    start    = 1'b0;
    start0   = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick(2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quotient", 32'(quo), 32'd0);
    chk("reset_remainder", 32'(rem), 32'd0);
    chk("reset_div_zero", 32'(dz), 32'd0);
    reset = 1'b0;
    tick(1);

    issue(16'd100, 16'd3, 16'd33, 16'd1, 1'b0);
    tick(3);
    chk("busy_running", 32'(busy), 32'd1);
    drain();

    // Same operands into both the rounding and truncating instances.
    dividend = 16'd200;
    divisor  = 16'd7;
    start    = 1'b1;
    start0   = 1'b1;
    sb.push_back('{q: 16'd29, r: 16'd4, dz: 1'b0, cyc: cyc + 18});
    sb0.push_back('{q: 16'd28, r: 16'd4, dz: 1'b0, cyc: cyc + 18});
    tick(1);
    start  = 1'b0;
    start0 = 1'b0;
    drain();

    issue(16'd400, 16'd5, 16'd80, 16'd0, 1'b0);
    drain();
    issue(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
    drain();
    issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
    drain();
    issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    drain();

    // Start while busy is dropped; start in the done cycle is taken back-to-back.
    c = cyc;
    issue(16'd100, 16'd3, 16'd33, 16'd1, 1'b0);
    tick(3);
    dividend = 16'd50;
    divisor  = 16'd2;
    start    = 1'b1;
    tick(1);
    start = 1'b0;
    while (cyc < c + 18) tick(1);
    start = 1'b1;
    sb.push_back('{q: 16'd25, r: 16'd0, dz: 1'b0, cyc: cyc + 18});
    tick(1);
    start    = 1'b0;
    dividend = 16'hBEEF;
    divisor  = 16'd1;
    drain();

    // Reset in the middle of a division aborts it without a done pulse.
    issue(16'd200, 16'd7, 16'd29, 16'd4, 1'b0);
    tick(7);
    reset = 1'b1;
    tick(1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_quotient", 32'(quo), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    tick(1);
    reset = 1'b0;
    tick(25);
    issue(16'd400, 16'd5, 16'd80, 16'd0, 1'b0);
    drain();

    // Start held high: a new division every WIDTH+2 cycles.
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    sb.push_back('{q: 16'd3, r: 16'd0, dz: 1'b0, cyc: cyc + 18});
    sb.push_back('{q: 16'd3, r: 16'd0, dz: 1'b0, cyc: cyc + 36});
    tick(20);
    start = 1'b0;
    drain();

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
